// File: rtl/thee_mathsci_consts_pkg.sv
// Shared mathematical constants for elaboration-time table generation.
package thee_mathsci_consts_pkg;

    localparam real const_pi = 3.14159265358979323846;

endpackage

// File: rtl/thee_sine_gen_pkg.sv
// Types, default parameters and the quarter-wave table builder for thee_sine_gen.
package thee_sine_gen_pkg;

    localparam int DEF_LUT_SIZE = 128;
    localparam int DEF_PHASE_W  = 16;
    localparam int DEF_AMP_W    = 16;
    localparam int DEF_FREQ_RST = 512;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } sine_state_e;

    // Entry k of the quarter table: round(sin(2*pi*k/lut_size) * full_scale); k <= lut_size/4 keeps it >= 0.
    function automatic int build_qlut(input int k, input int lut_size, input int amp_w);
        real fs;
        real v;
        fs = real'((longint'(1) << (amp_w - 1)) - 1);
        v  = $sin(2.0 * thee_mathsci_consts_pkg::const_pi * real'(k) / real'(lut_size)) * fs;
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/thee_sine_gen_if.sv
// Frequency-word handshake and sample stream of thee_sine_gen.
interface thee_sine_gen_if
    import thee_sine_gen_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int AMP_W   = DEF_AMP_W
) ();

    logic [PHASE_W-1:0]      freq_word;
    logic                    freq_valid;
    logic                    freq_ready;
    logic signed [AMP_W-1:0] sample_out;
    logic                    sample_valid;
    logic                    zc_pulse;

    modport master (
        output freq_word, freq_valid,
        input  freq_ready, sample_out, sample_valid, zc_pulse
    );

    modport slave (
        input  freq_word, freq_valid,
        output freq_ready, sample_out, sample_valid, zc_pulse
    );

endinterface

// File: rtl/thee_sine_qlut.sv
// Quarter-wave sine table with quadrant fold; purely combinational index -> signed sample.
module thee_sine_qlut
    import thee_sine_gen_pkg::*;
#(
    parameter int LUT_SIZE = DEF_LUT_SIZE,
    parameter int AMP_W    = DEF_AMP_W
) (
    input  logic [$clog2(LUT_SIZE)-1:0] idx,
    output logic signed [AMP_W-1:0]     sample
);

    localparam int IDX_W = $clog2(LUT_SIZE);
    localparam int KW    = IDX_W - 2;
    localparam int Q     = LUT_SIZE / 4;

    logic signed [AMP_W-1:0] lut [0:Q];

    for (genvar k = 0; k <= Q; k++) begin : g_lut
        localparam int ENTRY = build_qlut(k, LUT_SIZE, AMP_W);
        assign lut[k] = AMP_W'(ENTRY);
    end

    logic [1:0]              quad;
    logic [KW:0]             k_fwd;
    logic [KW:0]             k_rev;
    logic signed [AMP_W-1:0] mag;

    // Odd quadrants read the table backwards; the upper half negates, so the wave is exactly symmetric.
    always_comb begin
        quad   = idx[IDX_W-1 -: 2];
        k_fwd  = {1'b0, idx[KW-1:0]};
        k_rev  = (KW+1)'(Q) - k_fwd;
        mag    = quad[0] ? lut[k_rev] : lut[k_fwd];
        sample = quad[1] ? -mag : mag;
    end

endmodule

// File: rtl/thee_sine_gen.sv
// DDS sine source: phase accumulator, quarter-wave table, rising zero-crossing strobe.
// Optional real-valued output port ana_out under `THEE_SINEGEN_REAL_OUT_EN.
module thee_sine_gen
    import thee_sine_gen_pkg::*;
#(
    parameter int LUT_SIZE = DEF_LUT_SIZE,
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int AMP_W    = DEF_AMP_W,
    parameter int FREQ_RST = DEF_FREQ_RST
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic           stop,
    output logic           busy,
`ifdef THEE_SINEGEN_REAL_OUT_EN
    output real            ana_out,
`endif
    thee_sine_gen_if.slave sif
);

    localparam int IDX_W = $clog2(LUT_SIZE);

    sine_state_e             state_q, state_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [PHASE_W-1:0]      fw_active_q, fw_active_d;
    logic [PHASE_W-1:0]      pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic                    wrap_q, wrap_d;
    logic                    last_q, last_d;
    logic                    zc_q, zc_d;
    logic                    sample_valid_q, sample_valid_d;
    logic signed [AMP_W-1:0] sample_q, sample_d;
    logic signed [AMP_W-1:0] lut_sample;
    logic [PHASE_W:0]        sum;
    logic                    ready;
    logic                    accept;

    thee_sine_qlut #(
        .LUT_SIZE (LUT_SIZE),
        .AMP_W    (AMP_W)
    ) u_qlut (
        .idx    (phase_q[PHASE_W-1 -: IDX_W]),
        .sample (lut_sample)
    );

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        fw_active_d    = fw_active_q;
        pend_d         = pend_q;
        pend_valid_d   = pend_valid_q;
        wrap_d         = 1'b0;
        last_d         = 1'b0;
        zc_d           = 1'b0;
        sample_d       = '0;
        sample_valid_d = 1'b0;
        sum            = {1'b0, phase_q} + {1'b0, fw_active_q};
        ready          = (state_q == ST_IDLE) || !pend_valid_q;
        accept         = sif.freq_valid && ready;

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (accept) fw_active_d = sif.freq_word;
                if (start && !stop) state_d = ST_RUN;
            end
            ST_RUN, ST_DRAIN: begin
                phase_d        = sum[PHASE_W-1:0];
                wrap_d         = sum[PHASE_W];
                zc_d           = wrap_q;
                sample_d       = lut_sample;
                sample_valid_d = 1'b1;
                // Frequency changes only take effect at a wrap, keeping the waveform phase-continuous.
                if (sum[PHASE_W] && pend_valid_q) begin
                    fw_active_d  = pend_q;
                    pend_valid_d = 1'b0;
                end
                if (accept) begin
                    pend_d       = sif.freq_word;
                    pend_valid_d = 1'b1;
                end
                if (state_q == ST_RUN) begin
                    if (stop) state_d = ST_DRAIN;
                end else if (start) begin
                    state_d = ST_RUN;
                end else begin
                    // last_q marks that the post-wrap sample has just been shown while draining.
                    last_d = wrap_q;
                    if (last_q || (fw_active_q == '0)) begin
                        state_d        = ST_IDLE;
                        phase_d        = '0;
                        wrap_d         = 1'b0;
                        last_d         = 1'b0;
                        zc_d           = 1'b0;
                        sample_d       = '0;
                        sample_valid_d = 1'b0;
                        if (pend_valid_d) begin
                            fw_active_d  = pend_d;
                            pend_valid_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            fw_active_q    <= PHASE_W'(FREQ_RST);
            pend_q         <= '0;
            pend_valid_q   <= 1'b0;
            wrap_q         <= 1'b0;
            last_q         <= 1'b0;
            zc_q           <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_q       <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            fw_active_q    <= fw_active_d;
            pend_q         <= pend_d;
            pend_valid_q   <= pend_valid_d;
            wrap_q         <= wrap_d;
            last_q         <= last_d;
            zc_q           <= zc_d;
            sample_valid_q <= sample_valid_d;
            sample_q       <= sample_d;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign sif.freq_ready   = ready;
    assign sif.sample_out   = sample_q;
    assign sif.sample_valid = sample_valid_q;
    assign sif.zc_pulse     = zc_q;

`ifdef THEE_SINEGEN_REAL_OUT_EN
    localparam real FS_R = real'((longint'(1) << (AMP_W - 1)) - 1);

    real ana_q, ana_d;

    always_comb ana_d = real'(sample_d) / FS_R;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ana_q <= 0.0;
        else       ana_q <= ana_d;
    end

    assign ana_out = ana_q;
`endif

endmodule

// File: tb/tb_thee_sine_gen.sv
// Scoreboard bench for thee_sine_gen: directed test-plan scenarios followed by random traffic.
module tb_thee_sine_gen;
    import thee_sine_gen_pkg::*;

    localparam int  LUT_SIZE = 128;
    localparam int  PHASE_W  = 16;
    localparam int  AMP_W    = 16;
    localparam int  FREQ_RST = 512;
    localparam int  SH       = PHASE_W - $clog2(LUT_SIZE);
    localparam int  PMOD     = 1 << PHASE_W;
    localparam real FS       = real'((1 << (AMP_W - 1)) - 1);

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic busy;

    thee_sine_gen_if #(.PHASE_W(PHASE_W), .AMP_W(AMP_W)) sif ();

`ifdef THEE_SINEGEN_REAL_OUT_EN
    real ana_out;
`endif

    thee_sine_gen #(
        .LUT_SIZE (LUT_SIZE),
        .PHASE_W  (PHASE_W),
        .AMP_W    (AMP_W),
        .FREQ_RST (FREQ_RST)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .stop    (stop),
        .busy    (busy),
`ifdef THEE_SINEGEN_REAL_OUT_EN
        .ana_out (ana_out),
`endif
        .sif     (sif)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_real(input string name, input real act, input real exp);
        real d;
        d = act - exp;
        if (d < 0.0) d = -d;
        n_checks++;
        if (d <= 1.0e-9) n_pass++;
        else $display("FAIL %s: got %f, expected %f", name, act, exp);
    endtask

    // Ideal sine sample at table index idx, rounded half away from zero.
    function automatic int ref_sample(input int idx);
        real v, a;
        int  m;
        v = $sin(2.0 * thee_mathsci_consts_pkg::const_pi * real'(idx) / real'(LUT_SIZE));
        a = (v < 0.0) ? -v : v;
        m = $rtoi(a * FS + 0.5);
        return (v < 0.0) ? -m : m;
    endfunction

    typedef struct {
        int sample;
        bit zc;
        int idx;
    } exp_t;

    exp_t sb [$];

    // Behavioural reference: mode 0 idle, 1 generating, 2 finishing the current period.
    int m_mode, m_phase, m_fw, m_pend;
    bit m_pend_v, m_wrapped, m_exit;

    task automatic model_reset();
        m_mode    = 0;
        m_phase   = 0;
        m_fw      = FREQ_RST;
        m_pend    = 0;
        m_pend_v  = 1'b0;
        m_wrapped = 1'b0;
        m_exit    = 1'b0;
    endtask

    task automatic model_step();
        bit   rdy, acc, carried, zc, leave;
        int   nxt, idx;
        exp_t e;
        rdy = (m_mode == 0) || !m_pend_v;
        acc = sif.freq_valid && rdy;
        if (m_mode == 0) begin
            if (acc) m_fw = int'(sif.freq_word);
            m_phase = 0;
            if (start && !stop) m_mode = 1;
        end else begin
            idx     = m_phase >> SH;
            nxt     = m_phase + m_fw;
            carried = (nxt >= PMOD);
            zc      = m_wrapped;
            leave   = (m_mode == 2) && !start && (m_exit || m_fw == 0);
            if (!leave) begin
                e.sample = ref_sample(idx);
                e.zc     = zc;
                e.idx    = idx;
                sb.push_back(e);
            end
            m_exit    = (m_mode == 2) && zc;
            m_wrapped = carried;
            m_phase   = nxt % PMOD;
            if (carried && m_pend_v) begin
                m_fw     = m_pend;
                m_pend_v = 1'b0;
            end
            if (acc) begin
                m_pend   = int'(sif.freq_word);
                m_pend_v = 1'b1;
            end
            if (leave) begin
                m_mode    = 0;
                m_phase   = 0;
                m_wrapped = 1'b0;
                m_exit    = 1'b0;
                if (m_pend_v) m_fw = m_pend;
                m_pend_v = 1'b0;
            end else if (m_mode == 1 && stop) begin
                m_mode = 2;
            end else if (m_mode == 2 && start) begin
                m_mode = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rstn) model_reset();
            else       model_step();
        end
    end

    // Monitor: compares every presented sample against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                chk("busy", longint'(busy), longint'(m_mode != 0));
                chk("freq_ready", longint'(sif.freq_ready), longint'((m_mode == 0) || !m_pend_v));
                chk("sample_valid", longint'(sif.sample_valid), longint'(sb.size() != 0));
                if (sif.sample_valid && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk($sformatf("sample_idx%0d", e.idx), longint'(sif.sample_out), longint'(e.sample));
                    chk($sformatf("zc_idx%0d", e.idx), longint'(sif.zc_pulse), longint'(e.zc));
                end else if (!sif.sample_valid) begin
                    chk("idle_sample", longint'(sif.sample_out), 0);
                    chk("idle_zc", longint'(sif.zc_pulse), 0);
                    if (sb.size() != 0) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_valid"}, longint'(sif.sample_valid), 0);
        chk({tag, "_sample"}, longint'(sif.sample_out), 0);
        chk({tag, "_zc"}, longint'(sif.zc_pulse), 0);
        chk({tag, "_ready"}, longint'(sif.freq_ready), 1);
`ifdef THEE_SINEGEN_REAL_OUT_EN
        chk_real({tag, "_ana"}, ana_out, 0.0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        model_reset();
        sb.delete();
        #1;
        check_reset_outputs(tag);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic wait_zc(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sif.zc_pulse && n < budget);
        chk("zc_within_budget", longint'(sif.zc_pulse), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_within_budget", longint'(busy), 0);
    endtask

    task automatic write_freq(input int w);
        sif.freq_word  = PHASE_W'(w);
        sif.freq_valid = 1'b1;
        tick();
        sif.freq_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int n, n2;
        sif.freq_word  = '0;
        sif.freq_valid = 1'b0;
        #1;
        do_reset("reset");

        // Default 512 run: one table index per clock.
        pulse_start();
        tick();
        chk("first_sample", longint'(sif.sample_out), 0);
        chk("first_valid", longint'(sif.sample_valid), 1);
        chk("first_zc", longint'(sif.zc_pulse), 0);
        tick();
        chk("idx1", longint'(sif.sample_out), 1608);
        repeat (31) tick();
        chk("idx32_peak", longint'(sif.sample_out), 32767);
`ifdef THEE_SINEGEN_REAL_OUT_EN
        chk_real("ana_idx32", ana_out, 1.0);
`endif
        repeat (64) tick();
        chk("idx96_trough", longint'(sif.sample_out), -32767);
`ifdef THEE_SINEGEN_REAL_OUT_EN
        chk_real("ana_idx96", ana_out, -1.0);
`endif
        repeat (32) tick();
        chk("period128_zc", longint'(sif.zc_pulse), 1);
        chk("period128_sample", longint'(sif.sample_out), 0);

        // Stop at index 40: drain to the wrap, show the post-wrap sample, then go idle.
        repeat (40) tick();
        pulse_stop();
        wait_zc(300, n);
        chk("drain_last_sample", longint'(sif.sample_out), 0);
        chk("drain_last_busy", longint'(busy), 1);
        tick();
        chk("drain_done_busy", longint'(busy), 0);
        chk("drain_done_valid", longint'(sif.sample_valid), 0);

        // Word 1024 loaded in idle halves the period.
        write_freq(1024);
        pulse_start();
        wait_zc(300, n);
        wait_zc(300, n);
        chk("period64", n, 64);
        pulse_stop();
        wait_idle(300);

        // Mid-run change at index 40: old period completes, then 64-clock periods.
        write_freq(512);
        pulse_start();
        tick();
        repeat (40) tick();
        write_freq(1024);
        chk("pending_ready_low", longint'(sif.freq_ready), 0);
        wait_zc(300, n);
        chk("old_period_len", 41 + n, 128);
        chk("pending_ready_high", longint'(sif.freq_ready), 1);
        wait_zc(300, n2);
        chk("new_period_len", n2, 64);
        pulse_stop();
        wait_idle(300);

        // Reset mid-run (index 70) restores FREQ_RST and restarts from phase 0.
        pulse_start();
        tick();
        repeat (35) tick();
        do_reset("midrun_reset");
        pulse_start();
        tick();
        chk("restart_sample0", longint'(sif.sample_out), 0);
        chk("restart_zc", longint'(sif.zc_pulse), 0);
        tick();
        chk("restart_idx1", longint'(sif.sample_out), 1608);

        // Random traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            sif.freq_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 5))
                0:       sif.freq_word = '0;
                1:       sif.freq_word = PHASE_W'(512);
                2:       sif.freq_word = PHASE_W'(1024);
                3:       sif.freq_word = PHASE_W'($urandom_range(256, 65535));
                4:       sif.freq_word = PHASE_W'($urandom_range(200, 5000));
                default: sif.freq_word = PHASE_W'(4096);
            endcase
            if ($urandom_range(0, 999) == 0) begin
                start = 1'b0;
                stop  = 1'b0;
                sif.freq_valid = 1'b0;
                do_reset("rand_reset");
            end else begin
                tick();
            end
        end
        start = 1'b0;
        sif.freq_valid = 1'b0;
        pulse_stop();
        wait_idle(1000);
        tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
